// File: rtl/mandel_pixel_engine_pkg.sv
// Shared fixed-point definitions for the Mandelbrot pixel engine and the
// colour-mapping stage that follows it.
package mandel_pixel_engine_pkg;

   // Default fixed-point format: Q4.12 in 16 bits, range [-8, 8).
   localparam int PKG_WIDTH = 16;
   localparam int PKG_FRAC  = 12;

   // Escape radius squared (|z|^2 > 4) in the default format.
   localparam int ESCAPE = 4 << PKG_FRAC;

   // Widest operand fx_mul_shift accepts; callers sign-extend into it.
   localparam int MUL_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_e;

   // Full-precision signed product, rescaled back to the operands' format.
   function automatic logic signed [2*MUL_W-1:0] fx_mul_shift(
      input logic signed [MUL_W-1:0] a,
      input logic signed [MUL_W-1:0] b,
      input int                      frac
   );
      logic signed [2*MUL_W-1:0] prod;
      prod = (2*MUL_W)'(a) * (2*MUL_W)'(b);
      return prod >>> frac;
   endfunction

endpackage

// File: rtl/mandel_pixel_engine_if.sv
// Beam-in / result-out bundle between the display timing generator and the
// Mandelbrot pixel engine.
interface mandel_pixel_engine_if #(
   parameter int ITER_W = 7
) ();

   logic signed [15:0] i_sx;
   logic signed [15:0] i_sy;
   logic               i_de;
   logic               o_hold;
   logic               o_valid;
   logic [ITER_W-1:0]  o_iter;
   logic               o_in_set;

   // Timing-generator side: drives the beam, receives hold and results.
   modport master (
      output i_sx, i_sy, i_de,
      input  o_hold, o_valid, o_iter, o_in_set
   );

   // Engine side.
   modport slave (
      input  i_sx, i_sy, i_de,
      output o_hold, o_valid, o_iter, o_in_set
   );

endinterface

// File: rtl/mandel_pixel_engine_iter_step.sv
// One combinational Mandelbrot step: z' = z^2 + c, plus the escape test on
// the current z (|z|^2 > 4, strict).
module mandel_pixel_engine_iter_step
   import mandel_pixel_engine_pkg::*;
#(
   parameter int WIDTH = PKG_WIDTH,
   parameter int FRAC  = PKG_FRAC
) (
   input  logic signed [WIDTH-1:0] z_re,
   input  logic signed [WIDTH-1:0] z_im,
   input  logic signed [WIDTH-1:0] c_re,
   input  logic signed [WIDTH-1:0] c_im,
   output logic signed [WIDTH-1:0] z_re_nxt,
   output logic signed [WIDTH-1:0] z_im_nxt,
   output logic                    escape
);

   localparam int PW = 2 * WIDTH;

   // Equals ESCAPE when FRAC is the package default.
   localparam logic signed [PW:0] ESC_LIM = (PW+1)'(4 << FRAC);

   logic signed [PW-1:0] zr2;
   logic signed [PW-1:0] zi2;
   logic signed [PW-1:0] zri;
   logic signed [PW:0]   mag2;

   // Squares, cross term, escape test and the wrapped z update.
   always_comb begin
      zr2  = PW'(fx_mul_shift(MUL_W'(z_re), MUL_W'(z_re), FRAC));
      zi2  = PW'(fx_mul_shift(MUL_W'(z_im), MUL_W'(z_im), FRAC));
      zri  = PW'(fx_mul_shift(MUL_W'(z_re), MUL_W'(z_im), FRAC));
      // Magnitude kept at product width so squares of z near the edge of the
      // format (e.g. 5^2, 6^2) compare correctly instead of wrapping.
      mag2 = (PW+1)'(zr2) + (PW+1)'(zi2);
      escape   = (mag2 > ESC_LIM);
      // Outside the |c| < 4 envelope these wrap; no saturation is applied.
      z_re_nxt = WIDTH'(zr2 - zi2 + PW'(c_re));
      z_im_nxt = WIDTH'((zri <<< 1) + PW'(c_im));
   end

endmodule

// File: rtl/mandel_pixel_engine.sv
// Per-pixel Mandelbrot iterator. Freezes the timing generator through o_hold
// while a pixel iterates, one iteration per clock, and strobes o_valid with
// the iteration count when the pixel finishes.
module mandel_pixel_engine
   import mandel_pixel_engine_pkg::*;
#(
   parameter int WIDTH    = PKG_WIDTH,
   parameter int FRAC     = PKG_FRAC,
   parameter int MAX_ITER = 64,
   parameter int ITER_W   = 7,
   parameter int X0       = -10240,
   parameter int Y0       = -5400,
   parameter int DX       = 18,
   parameter int DY       = 18
) (
   input  logic                 i_pix_clk,
   input  logic                 i_rst,
   mandel_pixel_engine_if.slave pix
);

   localparam logic [ITER_W-1:0] N_MAX = ITER_W'(MAX_ITER);

   state_e                  state_q, state_d;
   logic signed [WIDTH-1:0] z_re_q, z_re_d;
   logic signed [WIDTH-1:0] z_im_q, z_im_d;
   logic signed [WIDTH-1:0] c_re_q, c_re_d;
   logic signed [WIDTH-1:0] c_im_q, c_im_d;
   logic [ITER_W-1:0]       n_q, n_d;
   logic [ITER_W-1:0]       iter_q, iter_d;
   logic                    in_set_q, in_set_d;

   logic signed [WIDTH-1:0] z_re_nxt;
   logic signed [WIDTH-1:0] z_im_nxt;
   logic                    escape;
   logic                    at_cap;
   int                      c_re_wide;
   int                      c_im_wide;

   mandel_pixel_engine_iter_step #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_step (
      .z_re     (z_re_q),
      .z_im     (z_im_q),
      .c_re     (c_re_q),
      .c_im     (c_im_q),
      .z_re_nxt (z_re_nxt),
      .z_im_nxt (z_im_nxt),
      .escape   (escape)
   );

   // Next-state, datapath and result-latch logic for the IDLE/ITER/DONE FSM.
   always_comb begin
      // NOTE: every _d takes its _q value first, so no branch can leave a
      // signal unassigned and infer a latch.
      state_d  = state_q;
      z_re_d   = z_re_q;
      z_im_d   = z_im_q;
      c_re_d   = c_re_q;
      c_im_d   = c_im_q;
      n_d      = n_q;
      iter_d   = iter_q;
      in_set_d = in_set_q;
      at_cap   = (n_q == N_MAX);

      // Pixel-to-plane mapping as 32-bit products, truncated to WIDTH below.
      c_re_wide = X0 + int'(pix.i_sx) * DX;
      c_im_wide = Y0 + int'(pix.i_sy) * DY;

      case (state_q)
         IDLE: begin
            if (pix.i_de) begin
               c_re_d  = c_re_wide[WIDTH-1:0];
               c_im_d  = c_im_wide[WIDTH-1:0];
               z_re_d  = '0;
               z_im_d  = '0;
               n_d     = '0;
               state_d = ITER;
            end
         end
         ITER: begin
            if (escape || at_cap) begin
               iter_d   = n_q;
               in_set_d = at_cap && !escape;
               state_d  = DONE;
            end else begin
               z_re_d = z_re_nxt;
               z_im_d = z_im_nxt;
               n_d    = n_q + ITER_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_pix_clk or posedge i_rst) begin
      // NOTE: the engine's state is a few small registers with no memory
      // array, so every one of them is reset.
      if (i_rst) begin
         state_q  <= IDLE;
         z_re_q   <= '0;
         z_im_q   <= '0;
         c_re_q   <= '0;
         c_im_q   <= '0;
         n_q      <= '0;
         iter_q   <= '0;
         in_set_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values present before this edge.
         state_q  <= state_d;
         z_re_q   <= z_re_d;
         z_im_q   <= z_im_d;
         c_re_q   <= c_re_d;
         c_im_q   <= c_im_d;
         n_q      <= n_d;
         iter_q   <= iter_d;
         in_set_q <= in_set_d;
      end
   end

   // Hold is released only on DONE, so the beam advances exactly once per
   // pixel; it drops immediately while reset is asserted.
   assign pix.o_hold   = pix.i_de && (state_q != DONE) && !i_rst;
   assign pix.o_valid  = (state_q == DONE);
   assign pix.o_iter   = iter_q;
   assign pix.o_in_set = in_set_q;

endmodule

// File: tb/tb_mandel_pixel_engine.sv
// Self-checking bench: directed corner pixels on an integer-grid instance,
// randomized pixels on a default-mapped instance, blanking and reset abort.
module tb_mandel_pixel_engine;

   localparam int MAX_ITER = 64;
   localparam int FRAC     = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mandel_pixel_engine_if #(.ITER_W(7)) ifa ();
   mandel_pixel_engine_if #(.ITER_W(7)) ifb ();

   // Instance A: c = (sx, sy) as integers.
   mandel_pixel_engine #(
      .X0 (0), .Y0 (0), .DX (4096), .DY (4096)
   ) dut_a (
      .i_pix_clk (clk),
      .i_rst     (rst),
      .pix       (ifa.slave)
   );

   // Instance B: default screen mapping.
   mandel_pixel_engine dut_b (
      .i_pix_clk (clk),
      .i_rst     (rst),
      .pix       (ifb.slave)
   );

   int total = 0;
   int bad   = 0;
   bit cur_sel = 1'b0;

   logic       s_hold, s_valid, s_set;
   logic [6:0] s_iter;

   always_comb begin
      s_hold  = cur_sel ? ifb.o_hold   : ifa.o_hold;
      s_valid = cur_sel ? ifb.o_valid  : ifa.o_valid;
      s_set   = cur_sel ? ifb.o_in_set : ifa.o_in_set;
      s_iter  = cur_sel ? ifb.o_iter   : ifa.o_iter;
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int wrap16(input longint v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   // Reference: iterate z = z^2 + c on integers scaled by 2^FRAC.
   function automatic void ref_pixel(input bit sel, input int sx, input int sy,
                                     output int iter, output bit in_set);
      int x0, y0, dx, dy, cr, ci, zr, zi;
      longint zr2, zi2, zri;
      if (sel) begin x0 = -10240; y0 = -5400; dx = 18;   dy = 18;   end
      else     begin x0 = 0;      y0 = 0;     dx = 4096; dy = 4096; end
      cr = wrap16(longint'(x0) + longint'(sx) * dx);
      ci = wrap16(longint'(y0) + longint'(sy) * dy);
      zr = 0; zi = 0; iter = MAX_ITER; in_set = 1'b1;
      for (int n = 0; n <= MAX_ITER; n++) begin
         zr2 = (longint'(zr) * zr) >>> FRAC;
         zi2 = (longint'(zi) * zi) >>> FRAC;
         zri = (longint'(zr) * zi) >>> FRAC;
         if (zr2 + zi2 > longint'(4 * 4096)) begin
            iter = n; in_set = 1'b0;
            return;
         end
         zr = wrap16(zr2 - zi2 + cr);
         zi = wrap16(2 * zri + ci);
      end
   endfunction

   task automatic set_beam(input bit sel, input int sx, input int sy, input bit de);
      if (sel) begin ifb.i_sx = 16'(sx); ifb.i_sy = 16'(sy); ifb.i_de = de; end
      else     begin ifa.i_sx = 16'(sx); ifa.i_sy = 16'(sy); ifa.i_de = de; end
   endtask

   // Called in the low clock phase with the pixel already presented; counts
   // hold cycles until DONE, then checks the result and blanks the beam.
   task automatic collect(input int exp_iter, input bit exp_set, input string tag);
      int  holds = 0;
      int  early = 0;
      bit  done  = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (!s_hold) begin
            done = 1'b1;
            break;
         end
         holds++;
         if (s_valid) early++;
         @(negedge clk);
      end
      check({tag, "_finished"}, int'(done), 1);
      check({tag, "_valid"}, int'(s_valid), 1);
      check({tag, "_early_valid"}, early, 0);
      check({tag, "_iter"}, int'(s_iter), exp_iter);
      check({tag, "_in_set"}, int'(s_set), int'(exp_set));
      check({tag, "_hold_cycles"}, holds, exp_iter + 2);
      @(posedge clk);
      #1;
      set_beam(cur_sel, 0, 0, 1'b0);
   endtask

   task automatic run_pixel(input bit sel, input int sx, input int sy, input string tag);
      int exp_iter;
      bit exp_set;
      cur_sel = sel;
      ref_pixel(sel, sx, sy, exp_iter, exp_set);
      @(posedge clk);
      #1;
      set_beam(sel, sx, sy, 1'b1);
      @(negedge clk);
      collect(exp_iter, exp_set, tag);
   endtask

   initial begin
      int hold_cnt, valid_cnt, exp_iter, last_iter;
      bit exp_set;

      set_beam(1'b1, 0, 0, 1'b0);
      set_beam(1'b0, 0, 0, 1'b1);   // de high during reset: hold must stay low
      #3;
      check("rst_hold", int'(ifa.o_hold), 0);
      check("rst_valid", int'(ifa.o_valid), 0);
      check("rst_iter", int'(ifa.o_iter), 0);
      check("rst_in_set", int'(ifa.o_in_set), 0);
      repeat (3) @(negedge clk);
      check("rst_hold_later", int'(ifa.o_hold), 0);
      set_beam(1'b0, 0, 0, 1'b0);
      rst = 1'b0;

      // Directed points on the real axis.
      run_pixel(1'b0, 0, 0, "c0");
      run_pixel(1'b0, 1, 0, "c1");
      run_pixel(1'b0, 3, 0, "c3");
      run_pixel(1'b0, 2, 0, "c2_boundary");
      ref_pixel(1'b0, 2, 0, last_iter, exp_set);

      // Blanking: beam free-runs, no hold, no results; outputs retained.
      cur_sel = 1'b0;
      hold_cnt = 0; valid_cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (ifa.o_hold || ifb.o_hold) hold_cnt++;
         if (ifa.o_valid || ifb.o_valid) valid_cnt++;
      end
      check("blank_hold", hold_cnt, 0);
      check("blank_valid", valid_cnt, 0);
      check("blank_iter_kept", int'(ifa.o_iter), last_iter);

      // Reset in the middle of the c=0 pixel.
      @(posedge clk);
      #1;
      set_beam(1'b0, 0, 0, 1'b1);
      repeat (10) @(negedge clk);
      check("abort_pre_hold", int'(ifa.o_hold), 1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_hold_drop", int'(ifa.o_hold), 0);
      check("abort_valid", int'(ifa.o_valid), 0);
      set_beam(1'b0, 1, 0, 1'b1);
      hold_cnt = 0; valid_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (ifa.o_hold) hold_cnt++;
         if (ifa.o_valid) valid_cnt++;
      end
      check("abort_hold_in_rst", hold_cnt, 0);
      check("abort_no_valid", valid_cnt, 0);
      rst = 1'b0;
      #1;
      ref_pixel(1'b0, 1, 0, exp_iter, exp_set);
      collect(exp_iter, exp_set, "after_abort");

      // Randomized pixels on both instances.
      for (int i = 0; i < 10; i++) begin
         int sx, sy;
         sx = int'($urandom_range(0, 6)) - 3;
         sy = int'($urandom_range(0, 6)) - 3;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_pixel(1'b0, sx, sy, $sformatf("rndA%0d_%0d_%0d", i, sx, sy));
      end
      for (int i = 0; i < 30; i++) begin
         int sx, sy;
         sx = int'($urandom_range(0, 639));
         sy = int'($urandom_range(0, 479));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_pixel(1'b1, sx, sy, $sformatf("rndB%0d_%0d_%0d", i, sx, sy));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
